// File: rtl/ahb_sram_slave_pkg.sv
// rtl/ahb_sram_slave_pkg.sv - shared types and constants for the AHB-Lite SRAM responder
package ahb_sram_slave_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_DATA  = 3'd1,
        ST_WR_DATA  = 3'd2,
        ST_RD_STALL = 3'd3,
        ST_ERR1     = 3'd4,
        ST_ERR2     = 3'd5
    } ahb_sram_state_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_sram_lane_dec.sv
// rtl/ahb_sram_lane_dec.sv - HSIZE/address to active-low byte lanes and misalignment flag
import ahb_sram_slave_pkg::*;

module ahb_sram_lane_dec (
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] ben,
    output logic       misaligned
);

    // Sizes above word fall through to the word encoding (all lanes)
    always_comb begin
        ben        = 4'h0;
        misaligned = 1'b0;
        case (hsize_t'(hsize))
            HSIZE_BYTE: ben = ~(4'b0001 << addr_lo);
            HSIZE_HALF: begin
                ben        = addr_lo[1] ? 4'b0011 : 4'b1100;
                misaligned = addr_lo[0];
            end
            HSIZE_WORD: misaligned = |addr_lo;
            default:    ben = 4'h0;
        endcase
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite responder for a single-port SRAM macro
// Optional error responses (range, size, alignment) under macro AHB_SRAM_ERR_EN.
import ahb_sram_slave_pkg::*;

module ahb_sram_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 4194304
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic        sram_cen,
    output logic        sram_wen,
    output logic [3:0]  sram_ben,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_din,
    input  logic [31:0] sram_dout
);

    localparam logic [31:0] MEM_SIZE  = 32'(MEM_BYTES);
    localparam logic [31:0] ADDR_MASK = MEM_SIZE - 32'd1;

    ahb_sram_state_t state;
    htrans_t         trans;
    logic            acc;
    logic            err_beat;
    logic            rd_go;
    logic            wr_go;
    logic [3:0]      lane_ben;
    logic            misaligned;
    logic [31:0]     map_addr;
    logic [31:0]     addr_q;
    logic [3:0]      ben_q;

    ahb_sram_lane_dec u_lane_dec (
        .hsize      (HSIZE),
        .addr_lo    (HADDR[1:0]),
        .ben        (lane_ben),
        .misaligned (misaligned)
    );

    assign trans    = htrans_t'(HTRANS);
    assign acc      = HSEL & HREADY & ~HRESET &
                      ((trans == HTRANS_NONSEQ) | (trans == HTRANS_SEQ));
    assign map_addr = ({HADDR[31:2], 2'b00} - BASE_ADDR) & ADDR_MASK;

`ifdef AHB_SRAM_ERR_EN
    logic [31:0] rng_off;
    logic        in_range;
    logic        unused_ok;

    assign rng_off   = HADDR - BASE_ADDR;
    assign in_range  = rng_off < MEM_SIZE;
    assign err_beat  = acc & (~in_range | (HSIZE > 3'd2) | misaligned);
    assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign unused_ok = ^HBURST;
`else
    logic unused_ok;

    assign err_beat  = 1'b0;
    assign HRESP     = HRESP_OKAY;
    assign unused_ok = ^{HBURST, misaligned};
`endif

    assign rd_go = acc & ~HWRITE & ~err_beat;
    assign wr_go = acc & HWRITE & ~err_beat;

    // ERR1 is the first (stalled) cycle of the two-cycle ERROR response
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state  <= ST_IDLE;
            addr_q <= 32'h0;
            ben_q  <= 4'hF;
        end else begin
            case (state)
                ST_RD_STALL: state <= ST_RD_DATA;
                ST_ERR1:     state <= ST_ERR2;
                default: begin
                    if (err_beat) begin
                        state <= ST_ERR1;
                    end else if (wr_go) begin
                        state  <= ST_WR_DATA;
                        addr_q <= map_addr;
                        ben_q  <= lane_ben;
                    end else if (rd_go) begin
                        if (state == ST_WR_DATA) begin
                            state  <= ST_RD_STALL;
                            addr_q <= map_addr;
                        end else begin
                            state <= ST_RD_DATA;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // The SRAM port is owned by a pending write first, then a stalled read,
    // then a read issued straight from the current address phase.
    always_comb begin
        sram_cen  = 1'b1;
        sram_wen  = 1'b1;
        sram_ben  = 4'hF;
        sram_addr = 32'h0;
        sram_din  = 32'h0;
        if (state == ST_WR_DATA) begin
            sram_cen  = 1'b0;
            sram_wen  = 1'b0;
            sram_ben  = ben_q;
            sram_addr = addr_q;
            sram_din  = HWDATA;
        end else if (state == ST_RD_STALL) begin
            sram_cen  = 1'b0;
            sram_addr = addr_q;
        end else if (rd_go) begin
            sram_cen  = 1'b0;
            sram_addr = map_addr;
        end
    end

    assign HREADYOUT = ~((state == ST_RD_STALL) || (state == ST_ERR1));
    assign HRDATA    = (state == ST_RD_DATA) ? sram_dout : 32'h0;

endmodule
